// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle turn sequencer.
package pbs_pkg;

  typedef enum logic [3:0] {
    ST_LOAD     = 4'd0,
    ST_WAIT_GO  = 4'd1,
    ST_P_ROLL   = 4'd2,
    ST_P_APPLY  = 4'd3,
    ST_P_CHECK  = 4'd4,
    ST_AI_ROLL  = 4'd5,
    ST_AI_APPLY = 4'd6,
    ST_AI_CHECK = 4'd7,
    ST_WIN      = 4'd8,
    ST_LOSE     = 4'd9
  } state_t;

  localparam logic TRAINER_PLAYER = 1'b0;
  localparam logic TRAINER_AI     = 1'b1;
  localparam logic TARGET_AI      = 1'b0;
  localparam logic TARGET_PLAYER  = 1'b1;

  // x^4 + x^3 + 1: feedback is the XOR of bits 3 and 2 of a left-shifting register
  localparam logic [3:0] LFSR_TAPS  = 4'b1100;
  localparam logic [3:0] ACC_ALWAYS = 4'hF;

endpackage

// File: rtl/pbs_lfsr4.sv
// Free-running 4-bit Fibonacci LFSR used for AI move draws and accuracy rolls.
module pbs_lfsr4
  import pbs_pkg::*;
#(
  parameter logic [3:0] SEED = 4'hA
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [3:0] lfsr
);

  // An all-zero seed would lock the register, so it is replaced by 1.
  localparam logic [3:0] SEED_NZ = (SEED == 4'h0) ? 4'h1 : SEED;

  // Shift left every clock, feeding back the tapped bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= SEED_NZ;
    end else begin
      lfsr <= {lfsr[2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/battle_turn_ctrl.sv
// Per-turn sequencer for the battle datapath: latch moves, roll accuracy,
// strobe damage, detect faint.
//
// state       | meaning
// ------------+---------------------------------------------------
// LOAD        | one-cycle pulse loading initial HPs
// WAIT_GO     | idle; watch HPs, wait for rising edge of go
// P_ROLL      | roll accuracy for the player's move
// P_APPLY     | strobe damage into AI HP if the roll hit
// P_CHECK     | AI fainted -> WIN, else AI attacks
// AI_ROLL     | roll accuracy for the AI's move
// AI_APPLY    | strobe damage into player HP if the roll hit
// AI_CHECK    | player fainted -> LOSE, else count the turn
// WIN / LOSE  | terminal until reset
module battle_turn_ctrl
  import pbs_pkg::*;
#(
  parameter int         HP_W      = 4,
  parameter logic [3:0] LFSR_SEED = 4'hA,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [1:0]       p_move,
  input  logic [HP_W-1:0]  accu_p,
  input  logic [HP_W-1:0]  accu_ai,
  input  logic [HP_W-1:0]  p_hp,
  input  logic [HP_W-1:0]  ai_hp,
  output logic             load_ai_hp,
  output logic             active_trainer,
  output logic             target,
  output logic             apply_ai_damage,
  output logic             apply_p_damage,
  output logic [1:0]       ai_move,
  output logic [1:0]       p_move_q,
  output logic [HP_W-1:0]  roll,
  output logic             hit,
  output logic             busy,
  output logic             victory,
  output logic             loss,
  output logic [CNT_W-1:0] turn_count,
  output logic [3:0]       state_dbg
);

  state_t          state_q, state_d;
  logic            go_q;
  logic            go_rise;
  logic [3:0]      lfsr;
  logic            latch_turn;
  logic            do_roll;
  logic            count_turn;
  logic [HP_W-1:0] roll_acc;
  logic [HP_W-1:0] roll_next;
  logic            hit_next;

  pbs_lfsr4 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .lfsr    (lfsr)
  );

  assign go_rise   = go & ~go_q;
  assign roll_acc  = (state_q == ST_AI_ROLL) ? accu_ai : accu_p;
  assign roll_next = HP_W'(lfsr);
  // Full accuracy always hits; zero accuracy can never satisfy the compare.
  assign hit_next  = (roll_acc == HP_W'(ACC_ALWAYS)) | (roll_next < roll_acc);
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and datapath enables.
  always_comb begin
    state_d    = state_q;
    latch_turn = 1'b0;
    do_roll    = 1'b0;
    count_turn = 1'b0;
    case (state_q)
      ST_LOAD:    state_d = ST_WAIT_GO;
      ST_WAIT_GO: begin
        // Player faint outranks AI faint when both are already zero.
        if (p_hp == '0) begin
          state_d = ST_LOSE;
        end else if (ai_hp == '0) begin
          state_d = ST_WIN;
        end else if (go_rise) begin
          state_d    = ST_P_ROLL;
          latch_turn = 1'b1;
        end
      end
      ST_P_ROLL: begin
        state_d = ST_P_APPLY;
        do_roll = 1'b1;
      end
      ST_P_APPLY: state_d = ST_P_CHECK;
      ST_P_CHECK: state_d = (ai_hp == '0) ? ST_WIN : ST_AI_ROLL;
      ST_AI_ROLL: begin
        state_d = ST_AI_APPLY;
        do_roll = 1'b1;
      end
      ST_AI_APPLY: state_d = ST_AI_CHECK;
      ST_AI_CHECK: begin
        if (p_hp == '0) begin
          state_d = ST_LOSE;
        end else begin
          state_d    = ST_WAIT_GO;
          count_turn = 1'b1;
        end
      end
      ST_WIN:  state_d = ST_WIN;
      ST_LOSE: state_d = ST_LOSE;
      default: state_d = ST_LOAD;
    endcase
  end

  // Moore output decode.
  always_comb begin
    load_ai_hp      = 1'b0;
    active_trainer  = TRAINER_PLAYER;
    target          = TARGET_AI;
    apply_ai_damage = 1'b0;
    apply_p_damage  = 1'b0;
    busy            = 1'b1;
    victory         = 1'b0;
    loss            = 1'b0;
    case (state_q)
      ST_LOAD:    load_ai_hp = 1'b1;
      ST_WAIT_GO: busy = 1'b0;
      ST_P_APPLY: apply_ai_damage = hit;
      ST_AI_ROLL, ST_AI_CHECK: begin
        active_trainer = TRAINER_AI;
        target         = TARGET_PLAYER;
      end
      ST_AI_APPLY: begin
        active_trainer = TRAINER_AI;
        target         = TARGET_PLAYER;
        apply_p_damage = hit;
      end
      ST_WIN: begin
        busy    = 1'b0;
        victory = 1'b1;
      end
      ST_LOSE: begin
        busy = 1'b0;
        loss = 1'b1;
      end
      default: ;
    endcase
    // Reset parks the FSM in LOAD; keep the LOAD-derived outputs quiet until release
    // so the HP load pulse only fires once the design is running.
    if (!reset_n) begin
      load_ai_hp = 1'b0;
      busy       = 1'b0;
    end
  end

  // Turn registers: edge detect, move latches, roll result, turn counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_q       <= 1'b1;
      p_move_q   <= '0;
      ai_move    <= '0;
      roll       <= '0;
      hit        <= 1'b0;
      turn_count <= '0;
    end else begin
      go_q <= go;
      if (latch_turn) begin
        p_move_q <= p_move;
        ai_move  <= lfsr[1:0];
      end
      if (do_roll) begin
        roll <= roll_next;
        hit  <= hit_next;
      end
      if (count_turn && (turn_count != '1)) begin
        turn_count <= turn_count + CNT_W'(1);
      end
    end
  end

endmodule
